// File: rtl/rank_order_encoder_fifo.sv
//------------------------------------------------------------------------------
// Module     : rank_order_encoder_fifo
// Description: Latches an image and emits the addresses of eligible pixels over
//              a 4-phase AER link, in rank (descending value) or index order.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rank_order_encoder_fifo #(
  parameter int IMAGE_SIZE      = 5,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_MAX_VALUE = 10,
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE),
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic [IMAGE_SIZE*(PIXEL_BITS+1)-1:0]    i_image,
  input  logic                                    i_new_image,
  input  logic                                    i_mode,
  input  logic [PIXEL_BITS:0]                     i_threshold,
  output logic                                    o_busy,
  output logic [IMAGE_SIZE_BITS:0]                o_spike_count,
  output logic                                    o_image_encoded,
  output logic [IMAGE_SIZE_BITS:0]                o_aerout_addr,
  output logic                                    o_aerout_req,
  input  logic                                    i_aerout_ack
);

  localparam int c_pix_w  = PIXEL_BITS + 1;
  localparam int c_addr_w = IMAGE_SIZE_BITS + 1;
  localparam int c_ptr_w  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w  = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_fifo_depth = c_cnt_w'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_DRAIN, ST_DONE} state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_WAIT} tx_state_t;

  state_t                r_state, w_state_nxt;
  tx_state_t             r_tx_state, w_tx_state_nxt;

  logic [c_pix_w-1:0]    r_pix [IMAGE_SIZE];
  logic                  r_mode;
  logic [c_pix_w-1:0]    r_thr;
  logic [IMAGE_SIZE-1:0] r_mask;
  logic                  r_busy;
  logic                  r_encoded;
  logic [c_addr_w-1:0]   r_spike_count;
  logic [c_addr_w-1:0]   r_addr;

  logic [c_addr_w-1:0]   r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr, r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;

  logic [IMAGE_SIZE-1:0] w_elig;
  logic [IMAGE_SIZE-1:0] w_sel_onehot;
  logic [c_addr_w-1:0]   w_sel_idx;
  logic [c_pix_w-1:0]    w_best;
  logic                  w_any;
  logic                  w_accept, w_push, w_pop, w_load, w_empty, w_req;

  generate
    for (genvar g = 0; g < IMAGE_SIZE; g++) begin : g_elig
      assign w_elig[g] = !r_mask[g] && (r_pix[g] >= r_thr);
    end
  endgenerate

  // Strict '>' keeps the lowest index on ties; index mode takes the first hit only.
  always_comb begin
    w_any        = 1'b0;
    w_sel_idx    = '0;
    w_sel_onehot = '0;
    w_best       = '0;
    for (int i = 0; i < IMAGE_SIZE; i++) begin
      if (w_elig[i] && (!w_any || (!r_mode && (r_pix[i] > w_best)))) begin
        w_any        = 1'b1;
        w_sel_idx    = i[c_addr_w-1:0];
        w_sel_onehot = '0;
        w_sel_onehot[i] = 1'b1;
        w_best       = r_pix[i];
      end
    end
  end

  assign w_empty = (r_count == '0);
  assign w_req   = (r_tx_state == TX_REQ);
  assign w_pop   = w_req && i_aerout_ack;
  assign w_load  = (r_tx_state == TX_IDLE) && !w_empty && !i_aerout_ack;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_new_image) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (!w_any)                        w_state_nxt = ST_DRAIN;
        else if (r_count < c_fifo_depth)   w_push      = 1'b1;
      end
      ST_DRAIN: begin
        if (w_empty && !w_req && !i_aerout_ack) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    case (r_tx_state)
      TX_IDLE: if (w_load)        w_tx_state_nxt = TX_REQ;
      TX_REQ:  if (i_aerout_ack)  w_tx_state_nxt = TX_WAIT;
      TX_WAIT: if (!i_aerout_ack) w_tx_state_nxt = TX_IDLE;
      default:                    w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_tx_state <= TX_IDLE;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_state <= w_tx_state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < IMAGE_SIZE; i++) r_pix[i] <= '0;
      r_mode        <= 1'b0;
      r_thr         <= '0;
      r_mask        <= '0;
      r_busy        <= 1'b0;
      r_encoded     <= 1'b0;
      r_spike_count <= '0;
      r_addr        <= '0;
    end else begin
      r_encoded <= (r_state == ST_DONE);
      if (w_accept) begin
        for (int i = 0; i < IMAGE_SIZE; i++) r_pix[i] <= i_image[i*c_pix_w +: c_pix_w];
        r_mode        <= i_mode;
        r_thr         <= i_threshold;
        r_mask        <= '0;
        r_busy        <= 1'b1;
        r_spike_count <= '0;
      end else begin
        if (w_push)               r_mask        <= r_mask | w_sel_onehot;
        if (r_state == ST_DONE)   r_busy        <= 1'b0;
        if (w_pop)                r_spike_count <= r_spike_count + 1'b1;
      end
      if (w_load) r_addr <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_sel_idx;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_busy          = r_busy;
  assign o_spike_count   = r_spike_count;
  assign o_image_encoded = r_encoded;
  assign o_aerout_addr   = r_addr;
  assign o_aerout_req    = w_req;

endmodule

`default_nettype wire
